stack_unit: RTL

STACK_UNIT -- requirements
Module: stack_unit

---
 rtl/stack_unit.sv | 120 ++++++++++++
 1 files changed

// File: rtl/stack_unit.sv
// LIFO stack with registered read port, push/pop/tos and replace-top (push+pop).
// Define STACK_ERR_EN to add the sticky ovf_err / unf_err outputs.
module stack_unit #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     tos,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
`ifdef STACK_ERR_EN
  ,
  output logic                     ovf_err,
  output logic                     unf_err
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   SP_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   SP_FULL = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] IDX_ONE = AW'(1);

  logic [AW:0]       sp_q, sp_d;
  logic [WIDTH-1:0]  dout_q, dout_d;
  logic [WIDTH-1:0]  mem [DEPTH];

  logic              we;
  logic              mem_we;
  logic [AW-1:0]     waddr;
  logic [AW-1:0]     top_idx;
  logic [WIDTH-1:0]  top;

  assign full    = (sp_q == SP_FULL);
  assign empty   = (sp_q == '0);
  assign count   = sp_q;
  assign dout    = dout_q;

  // At sp==DEPTH the low bits wrap to 0, so subtracting one still lands on DEPTH-1.
  assign top_idx = sp_q[AW-1:0] - IDX_ONE;
  assign top     = empty ? '0 : mem[top_idx];

  always_comb begin
    sp_d   = sp_q;
    dout_d = dout_q;
    we     = 1'b0;
    waddr  = sp_q[AW-1:0];
    if (push && pop) begin
      if (!empty) begin
        dout_d = top;
        we     = 1'b1;
        waddr  = top_idx;
      end else begin
        we   = 1'b1;
        sp_d = sp_q + SP_ONE;
      end
    end else if (push) begin
      if (!full) begin
        if (tos) begin
          dout_d = top;
        end
        we   = 1'b1;
        sp_d = sp_q + SP_ONE;
      end
    end else if (pop) begin
      if (!empty) begin
        dout_d = top;
        sp_d   = sp_q - SP_ONE;
      end
    end else if (tos) begin
      dout_d = top;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp_q   <= '0;
      dout_q <= '0;
    end else begin
      sp_q   <= sp_d;
      dout_q <= dout_d;
    end
  end

  // Storage is deliberately not reset; a reset cycle must still never commit a write.
  assign mem_we = we & ~rst;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[waddr] <= din;
    end
  end

`ifdef STACK_ERR_EN
  logic ovf_q, unf_q;
  logic ovf_ev, unf_ev;

  assign ovf_ev = push && !pop && full;
  assign unf_ev = pop && empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_q | ovf_ev;
      unf_q <= unf_q | unf_ev;
    end
  end

  assign ovf_err = ovf_q;
  assign unf_err = unf_q;
`endif

endmodule
